// File: rtl/alu_issue_ctrl.sv
// ALU operand/opcode issue controller: request handshake, settle wait, result capture, HI/LO and halt.
// Optional: define ALU_DIV0_EN to short-circuit div-by-zero as an error response.
module alu_issue_ctrl #(
  parameter int SETTLE_LAT = 1,
  parameter int MULDIV_LAT = 4
) (
  input  logic        clock,
  input  logic        clear,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [4:0]  req_opcode,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic        rsp_err,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out,
  output logic        halted,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [4:0]  alu_opcode,
  input  logic [63:0] alu_c
);
  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] ISSUE  = 3'd1;
  localparam logic [2:0] WAIT   = 3'd2;
  localparam logic [2:0] RESP   = 3'd3;
  localparam logic [2:0] HALTED = 3'd4;

  localparam logic [4:0] OP_MUL  = 5'b01110;
  localparam logic [4:0] OP_DIV  = 5'b01111;
  localparam logic [4:0] OP_MFHI = 5'b10111;
  localparam logic [4:0] OP_MFLO = 5'b11000;
  localparam logic [4:0] OP_NOP  = 5'b11001;
  localparam logic [4:0] OP_HALT = 5'b11010;

  localparam int MAX_LAT = (MULDIV_LAT > SETTLE_LAT) ? MULDIV_LAT : SETTLE_LAT;
  localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

  logic [2:0]       state;
  logic [4:0]       op_q;
  logic [31:0]      a_q, b_q;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      hi_q, lo_q;

  logic        req_alu, req_div0, op_muldiv;
  logic [31:0] short_res;
  logic        short_err;

  always_comb begin
    req_alu = (req_opcode >= 5'b00011) && (req_opcode <= 5'b10001);
`ifdef ALU_DIV0_EN
    req_div0 = (req_opcode == OP_DIV) && (req_b == 32'd0);
`else
    req_div0 = 1'b0;
`endif
    short_res = 32'd0;
    short_err = 1'b0;
    case (req_opcode)
      OP_MFHI:         short_res = hi_q;
      OP_MFLO:         short_res = lo_q;
      OP_NOP, OP_HALT: short_err = 1'b0;
      default:         short_err = 1'b1;  // unsupported codes and trapped div-by-zero
    endcase
  end

  assign op_muldiv = (op_q == OP_MUL) || (op_q == OP_DIV);

  always_ff @(posedge clock) begin
    if (clear) begin
      state      <= IDLE;
      op_q       <= OP_NOP;
      a_q        <= 32'd0;
      b_q        <= 32'd0;
      cnt        <= '0;
      hi_q       <= 32'd0;
      lo_q       <= 32'd0;
      rsp_result <= 32'd0;
      rsp_err    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          op_q <= req_opcode;
          a_q  <= req_a;
          b_q  <= req_b;
          if (req_alu && !req_div0) begin
            state <= ISSUE;
          end else begin
            state      <= RESP;
            rsp_result <= short_res;
            rsp_err    <= short_err;
          end
        end
        ISSUE: begin
          cnt   <= op_muldiv ? CNT_W'(MULDIV_LAT - 1) : CNT_W'(SETTLE_LAT - 1);
          state <= WAIT;
        end
        WAIT: if (cnt == '0) begin
          rsp_result <= alu_c[31:0];
          rsp_err    <= 1'b0;
          if (op_muldiv) begin
            hi_q <= alu_c[63:32];
            lo_q <= alu_c[31:0];
          end
          state <= RESP;
        end else begin
          cnt <= cnt - 1'b1;
        end
        RESP: if (rsp_ready) state <= (op_q == OP_HALT) ? HALTED : IDLE;
        HALTED: state <= HALTED;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    req_ready  = (state == IDLE);
    rsp_valid  = (state == RESP);
    halted     = (state == HALTED);
    hi_out     = hi_q;
    lo_out     = lo_q;
    alu_a      = 32'd0;
    alu_b      = 32'd0;
    alu_opcode = OP_NOP;
    if (state == ISSUE || state == WAIT) begin
      alu_a      = a_q;
      alu_b      = b_q;
      alu_opcode = op_q;
    end
  end
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Self-checking bench for alu_issue_ctrl: directed table, randomized ops vs reference model, corner sequences.
module tb_alu_issue_ctrl;
  localparam int SL = 1;
  localparam int ML = 4;
  localparam logic [4:0] NOP = 5'b11001, HALT = 5'b11010, MUL = 5'b01110, DIV = 5'b01111;
  localparam logic [4:0] MFHI = 5'b10111, MFLO = 5'b11000, ADD = 5'b00011;

  logic        clock = 1'b0, clear = 1'b1;
  logic        req_valid = 1'b0, rsp_ready = 1'b0;
  logic [4:0]  req_opcode = 5'd0;
  logic [31:0] req_a = 32'd0, req_b = 32'd0;
  logic        req_ready, rsp_valid, rsp_err, halted;
  logic [31:0] rsp_result, hi_out, lo_out, alu_a, alu_b;
  logic [4:0]  alu_opcode;
  logic [63:0] alu_c;

  int n_chk = 0, n_fail = 0;
  logic [31:0] m_hi = 32'd0, m_lo = 32'd0;

  alu_issue_ctrl #(.SETTLE_LAT(SL), .MULDIV_LAT(ML)) dut (
    .clock(clock), .clear(clear), .req_valid(req_valid), .req_ready(req_ready),
    .req_opcode(req_opcode), .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_result(rsp_result), .rsp_err(rsp_err), .hi_out(hi_out),
    .lo_out(lo_out), .halted(halted), .alu_a(alu_a), .alu_b(alu_b),
    .alu_opcode(alu_opcode), .alu_c(alu_c));

  always #5 clock = ~clock;

  // Behavioural ALU; div returns {remainder, quotient}, div-by-zero a fixed marker.
  function automatic logic [63:0] alu_math(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ab;
    ab = {a, a};
    case (op)
      5'd3, 5'd11: return {32'd0, a + b};
      5'd4:        return {32'd0, a - b};
      5'd5:        return {32'd0, a >> b[4:0]};
      5'd6:        return {32'd0, a << b[4:0]};
      5'd7:        return {32'd0, 32'(ab >> b[4:0])};
      5'd8:        return {32'd0, 32'((ab << b[4:0]) >> 32)};
      5'd9, 5'd12: return {32'd0, a & b};
      5'd10, 5'd13: return {32'd0, a | b};
      5'd14:       return 64'(a) * 64'(b);
      5'd15:       return (b == 32'd0) ? {32'hDEAD_BEEF, 32'hFFFF_FFFF} : {a % b, a / b};
      5'd16:       return {32'd0, -a};
      5'd17:       return {32'd0, ~a};
      default:     return 64'h0BAD_0BAD_0BAD_0BAD;
    endcase
  endfunction

  always_comb alu_c = alu_math(alu_opcode, alu_a, alu_b);

  // Reference model of controller rules: result, error, latency (edges after E0), HI/LO update.
  task automatic ref_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output logic err, output int lat);
    logic [63:0] r;
    res = 32'd0; err = 1'b0; lat = 0;
    if (op >= 5'd3 && op <= 5'd17) begin
`ifdef ALU_DIV0_EN
      if (op == DIV && b == 32'd0) begin err = 1'b1; return; end
`endif
      r   = alu_math(op, a, b);
      res = r[31:0];
      lat = 1 + ((op == MUL || op == DIV) ? ML : SL);
      if (op == MUL || op == DIV) begin m_hi = r[63:32]; m_lo = r[31:0]; end
    end else if (op == MFHI) res = m_hi;
    else if (op == MFLO) res = m_lo;
    else if (op != NOP && op != HALT) err = 1'b1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock); #1;
  endtask

  task automatic do_reset();
    clear = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
    tick(); tick();
    clear = 1'b0;
    m_hi = 32'd0; m_lo = 32'd0;
  endtask

  // One full transaction: accept, latency, ALU drive, result, backpressure hold, release.
  task automatic do_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b, input int dly,
                       input logic [31:0] e_res, input logic e_err, input int e_lat,
                       input logic [31:0] e_hi, input logic [31:0] e_lo);
    int n; logic bad, busy;
    n = 0;
    while (!req_ready && n < 10) begin tick(); n++; end
    chk("req_ready_before_op", 64'(req_ready), 64'd1);
    busy = (e_lat != 0);
    req_valid = 1'b1; req_opcode = op; req_a = a; req_b = b;
    tick();
    req_valid = 1'b0; req_a = $urandom; req_b = $urandom; req_opcode = 5'($urandom);
    n = 0; bad = 1'b0;
    while (!rsp_valid && n < 40) begin
      if (busy && (alu_opcode != op || alu_a != a || alu_b != b)) bad = 1'b1;
      if (!busy && alu_opcode != NOP) bad = 1'b1;
      if (req_ready) bad = 1'b1;
      tick(); n++;
    end
    chk("latency", 64'(n), 64'(e_lat));
    chk("alu_drive_in_flight", 64'(bad), 64'd0);
    chk("alu_idle_in_resp", {27'd0, alu_opcode, alu_a}, {27'd0, NOP, 32'd0});
    chk("rsp_result", 64'(rsp_result), 64'(e_res));
    chk("rsp_err", 64'(rsp_err), 64'(e_err));
    chk("hi_lo", {hi_out, lo_out}, {e_hi, e_lo});
    bad = 1'b0;
    for (int i = 0; i < dly; i++) begin
      req_valid = 1'b1; req_opcode = ADD;
      tick();
      if (!rsp_valid || rsp_result != e_res || rsp_err != e_err || req_ready) bad = 1'b1;
    end
    if (dly > 0) chk("backpressure_hold", 64'(bad), 64'd0);
    req_valid = 1'b0; rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("rsp_released", 64'(rsp_valid), 64'd0);
    chk("ready_after_rsp", {62'd0, req_ready, halted}, {62'd0, op != HALT, op == HALT});
  endtask

  typedef struct {
    logic [4:0] op; logic [31:0] a, b, res; logic err; int lat; logic [31:0] hi, lo;
  } vec_t;
  vec_t tbl[12];

  initial begin
    logic [31:0] r; logic e; int l; logic [4:0] op; logic [31:0] a, b; logic bad;
    tbl[0]  = '{ADD,   32'd5,       32'd7,       32'd12,        1'b0, 2, 32'd0, 32'd0};
    tbl[1]  = '{MUL,   32'h10000,   32'h10000,   32'd0,         1'b0, 5, 32'd1, 32'd0};
    tbl[2]  = '{MFHI,  32'd0,       32'd0,       32'd1,         1'b0, 0, 32'd1, 32'd0};
    tbl[3]  = '{MFLO,  32'd9,       32'd9,       32'd0,         1'b0, 0, 32'd1, 32'd0};
    tbl[4]  = '{5'd4,  32'd3,       32'd5,       32'hFFFF_FFFE, 1'b0, 2, 32'd1, 32'd0};
    tbl[5]  = '{5'd0,  32'd1,       32'd2,       32'd0,         1'b1, 0, 32'd1, 32'd0};
    tbl[6]  = '{5'd31, 32'd1,       32'd2,       32'd0,         1'b1, 0, 32'd1, 32'd0};
    tbl[7]  = '{DIV,   32'd100,     32'd7,       32'd14,        1'b0, 5, 32'd2, 32'd14};
    tbl[8]  = '{MFHI,  32'd0,       32'd0,       32'd2,         1'b0, 0, 32'd2, 32'd14};
    tbl[9]  = '{NOP,   32'd3,       32'd3,       32'd0,         1'b0, 0, 32'd2, 32'd14};
    tbl[10] = '{5'd6,  32'd1,       32'd4,       32'd16,        1'b0, 2, 32'd2, 32'd14};
    tbl[11] = '{5'd7,  32'd1,       32'd1,       32'h8000_0000, 1'b0, 2, 32'd2, 32'd14};

    do_reset();
    chk("reset_ready_valid", {62'd0, req_ready, rsp_valid}, {62'd0, 1'b1, 1'b0});
    chk("reset_hi_lo", {hi_out, lo_out}, 64'd0);
    chk("reset_rsp", {31'd0, rsp_err, rsp_result}, 64'd0);
    chk("reset_alu", {27'd0, alu_opcode, alu_a | alu_b}, {27'd0, NOP, 32'd0});
    chk("reset_halted", 64'(halted), 64'd0);

    for (int i = 0; i < 12; i++)
      do_op(tbl[i].op, tbl[i].a, tbl[i].b, (i == 0) ? 3 : i % 2,
            tbl[i].res, tbl[i].err, tbl[i].lat, tbl[i].hi, tbl[i].lo);

    do_reset();
    for (int i = 0; i < 60; i++) begin
      op = 5'($urandom_range(0, 31));
      if (op == HALT) op = NOP;
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? 32'd0 : (($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(1, 40)));
      ref_op(op, a, b, r, e, l);
      do_op(op, a, b, $urandom_range(0, 2), r, e, l, m_hi, m_lo);
    end

    // Clear during the second WAIT cycle of a div.
    do_op(MUL, 32'd3, 32'd5, 0, 32'd15, 1'b0, 5, 32'd0, 32'd15);
    req_valid = 1'b1; req_opcode = DIV; req_a = 32'd100; req_b = 32'd3;
    tick(); req_valid = 1'b0;
    tick(); tick();
    clear = 1'b1; tick(); clear = 1'b0;
    m_hi = 32'd0; m_lo = 32'd0;
    chk("clear_mid_div_state", {61'd0, rsp_valid, req_ready, halted}, {61'd0, 3'b010});
    chk("clear_mid_div_hilo", {hi_out, lo_out}, 64'd0);
    chk("clear_mid_div_alu", {27'd0, alu_opcode, alu_a}, {27'd0, NOP, 32'd0});

    // Div-by-zero with known HI/LO.
    do_op(MUL, 32'h10000, 32'h30000, 0, 32'd0, 1'b0, 5, 32'd3, 32'd0);
`ifdef ALU_DIV0_EN
    do_op(DIV, 32'd9, 32'd0, 1, 32'd0, 1'b1, 0, 32'd3, 32'd0);
`else
    do_op(DIV, 32'd9, 32'd0, 1, 32'hFFFF_FFFF, 1'b0, 5, 32'hDEAD_BEEF, 32'hFFFF_FFFF);
`endif

    // Halt: stays halted, ignores requests, keeps HI/LO, until clear.
    do_op(MFHI, 32'd0, 32'd0, 0, hi_out === 32'd3 ? 32'd3 : 32'hDEAD_BEEF, 1'b0, 0,
`ifdef ALU_DIV0_EN
          32'd3, 32'd0);
`else
          32'hDEAD_BEEF, 32'hFFFF_FFFF);
`endif
    do_op(HALT, 32'd1, 32'd1, 2, 32'd0, 1'b0, 0, hi_out, lo_out);
    bad = 1'b0;
    for (int i = 0; i < 6; i++) begin
      req_valid = 1'b1; req_opcode = ADD; rsp_ready = 1'b1;
      tick();
      if (req_ready || !halted || rsp_valid || alu_opcode != NOP) bad = 1'b1;
    end
    req_valid = 1'b0; rsp_ready = 1'b0;
    chk("halted_sticky", 64'(bad), 64'd0);
`ifdef ALU_DIV0_EN
    chk("halted_hilo_kept", {hi_out, lo_out}, {32'd3, 32'd0});
`else
    chk("halted_hilo_kept", {hi_out, lo_out}, {32'hDEAD_BEEF, 32'hFFFF_FFFF});
`endif
    do_reset();
    chk("clear_from_halt", {62'd0, req_ready, halted}, {62'd0, 1'b1, 1'b0});

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
